// File: rtl/dl1_write_buffer.sv
// Data-L1 write buffer: FIFO of pending write-misses with same-cycle lookup and a trigger/ack/done/read drain to L2.
// Optional write coalescing is enabled by defining DL1_WB_COALESCE_EN.
module dl1_write_buffer #(
   parameter int unsigned DATA_LENGTH = 32,
   parameter int unsigned WB_DEPTH    = 4,
   parameter int unsigned BYTE_OFFSET = 2,
   parameter int unsigned WORD_OFFSET = 2
) (
   input  logic                   cache_clk,
   input  logic                   rst,
   input  logic                   wb_write,
   input  logic [DATA_LENGTH-1:0] wb_addr,
   input  logic [DATA_LENGTH-1:0] wb_wdata,
   input  logic [DATA_LENGTH-1:0] lookup_addr,
   output logic                   wb_hit,
   output logic [DATA_LENGTH-1:0] wb_hit_data,
   output logic                   wb_read_tag_hit,
   output logic                   wb_full,
   output logic                   wb_empty,
   output logic                   wb_overflow,
   output logic                   wb_underflow,
   input  logic                   wb_trigger,
   output logic                   wb_done,
   input  logic                   wb_read,
   output logic                   l2_req,
   output logic [DATA_LENGTH-1:0] l2_addr,
   output logic [DATA_LENGTH-1:0] l2_wdata,
   input  logic                   l2_ack
);

   localparam int unsigned PTR_W   = $clog2(WB_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned BLK_LSB = BYTE_OFFSET + WORD_OFFSET;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t                 state;
   logic [WB_DEPTH-1:0]    valid;
   logic [DATA_LENGTH-1:0] addr_q [WB_DEPTH];
   logic [DATA_LENGTH-1:0] data_q [WB_DEPTH];
   logic [PTR_W-1:0]       head;
   logic [PTR_W-1:0]       tail;
   logic [CNT_W-1:0]       count;

   logic                   coalesce;
   logic                   head_coalesce;
   logic                   alloc;
   logic                   pop;
   logic [PTR_W-1:0]       lk_idx;
   logic                   lookup_unused;

   assign lookup_unused = ^lookup_addr[BYTE_OFFSET-1:0];

   assign wb_full  = (count == CNT_W'(WB_DEPTH));
   assign wb_empty = (count == '0);

   // Scan from the head so the last match found is the youngest entry.
   always_comb begin
      wb_hit          = 1'b0;
      wb_hit_data     = '0;
      wb_read_tag_hit = 1'b0;
      lk_idx          = '0;
      for (int unsigned k = 0; k < WB_DEPTH; k++) begin
         lk_idx = head + PTR_W'(k);
         if (valid[lk_idx] &&
             addr_q[lk_idx][DATA_LENGTH-1:BYTE_OFFSET] == lookup_addr[DATA_LENGTH-1:BYTE_OFFSET]) begin
            wb_hit      = 1'b1;
            wb_hit_data = data_q[lk_idx];
         end
         if (valid[lk_idx] &&
             addr_q[lk_idx][DATA_LENGTH-1:BLK_LSB] == lookup_addr[DATA_LENGTH-1:BLK_LSB])
            wb_read_tag_hit = 1'b1;
      end
   end

`ifdef DL1_WB_COALESCE_EN
   logic             co_hit;
   logic [PTR_W-1:0] co_idx;
   logic [PTR_W-1:0] ps_idx;

   // The head is off-limits once its drain has started: L2 already holds its data.
   always_comb begin
      co_hit = 1'b0;
      co_idx = '0;
      ps_idx = '0;
      for (int unsigned k = 0; k < WB_DEPTH; k++) begin
         ps_idx = head + PTR_W'(k);
         if (valid[ps_idx] &&
             addr_q[ps_idx][DATA_LENGTH-1:BYTE_OFFSET] == wb_addr[DATA_LENGTH-1:BYTE_OFFSET] &&
             !(ps_idx == head && state != S_IDLE)) begin
            co_hit = 1'b1;
            co_idx = ps_idx;
         end
      end
   end

   assign coalesce      = wb_write && co_hit;
   assign head_coalesce = coalesce && (co_idx == head);
`else
   assign coalesce      = 1'b0;
   assign head_coalesce = 1'b0;
`endif

   assign alloc = wb_write && !coalesce && !wb_full;
   assign pop   = wb_read && (state == S_DONE);

   always_ff @(posedge cache_clk) begin
      if (alloc) begin
         addr_q[tail] <= wb_addr;
         data_q[tail] <= wb_wdata;
      end
`ifdef DL1_WB_COALESCE_EN
      else if (coalesce) begin
         data_q[co_idx] <= wb_wdata;
      end
`endif
   end

   always_ff @(posedge cache_clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         valid        <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         l2_req       <= 1'b0;
         wb_done      <= 1'b0;
         l2_addr      <= '0;
         l2_wdata     <= '0;
         wb_overflow  <= 1'b0;
         wb_underflow <= 1'b0;
      end else begin
         wb_overflow  <= wb_write && !coalesce && wb_full;
         wb_underflow <= wb_read && (state != S_DONE);
         if (alloc) begin
            valid[tail] <= 1'b1;
            tail        <= tail + 1'b1;
         end
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         count <= count + CNT_W'(alloc) - CNT_W'(pop);
         case (state)
            S_IDLE: begin
               if (wb_trigger && !wb_empty) begin
                  state    <= S_REQ;
                  l2_req   <= 1'b1;
                  l2_addr  <= addr_q[head];
                  l2_wdata <= head_coalesce ? wb_wdata : data_q[head];
               end
            end
            S_REQ: begin
               if (l2_ack) begin
                  state   <= S_DONE;
                  l2_req  <= 1'b0;
                  wb_done <= 1'b1;
               end
            end
            S_DONE: begin
               if (wb_read) begin
                  state    <= S_IDLE;
                  wb_done  <= 1'b0;
                  l2_addr  <= '0;
                  l2_wdata <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
